// File: rtl/vote_relay_pkg.sv
// Shared types and defaults for the vote_relay peer station.
// States follow one handshake round: request, evaluate, reply, release.
package vote_relay_pkg;

  typedef logic [3:0] vote_t;

  localparam vote_t DECISION_DEF = 4'b0110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_EVAL,
    ST_WAITCTR,
    ST_SEND,
    ST_REL,
    ST_FIN
  } state_t;

  // States in which the voter can stall us; only these run the wait timer.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_REQ) || (s == ST_WAITCTR) || (s == ST_SEND);
  endfunction

endpackage

// File: rtl/vote_relay_hs_timer.sv
// Saturating wait counter; o_expired is high once LIMIT cycles have elapsed.
// Latency: the count is registered; clear has priority over enable.
module hs_timer #(
  parameter int LIMIT = 255,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LIM);

endmodule

// File: rtl/vote_relay.sv
// Peer station for the voting controller: captures a vote, replies with vote^mask, stops on decision/limit/timeout.
// Outputs are registered from the next state; each wait state is bounded by TIMEOUT cycles.
module vote_relay
  import vote_relay_pkg::*;
#(
  parameter int    MAX_ROUNDS = 15,
  parameter int    TIMEOUT    = 255,
  parameter vote_t DECISION   = DECISION_DEF
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_cts,
  input  logic       i_ctr,
  input  logic [3:0] i_v_out,
  input  logic [3:0] i_mask,
  output logic       o_rtr,
  output logic       o_rts,
  output logic [3:0] o_v_in,
  output logic       o_done,
  output logic       o_decided,
  output logic       o_error,
  output logic [3:0] o_rounds
);

  localparam logic [3:0] MAXR = 4'(MAX_ROUNDS);

  state_t r_state;
  state_t w_nxt;

  vote_t r_cap;
  vote_t r_m;
  vote_t r_v_in;
  logic  r_cts_low;
  logic  r_rtr;
  logic  r_rts;
  logic  r_done;
  logic  r_decided;
  logic  r_error;
  logic  [3:0] r_rounds;

  logic w_expired;
  logic w_start;
  logic w_capture;
  logic w_load_reply;
  logic w_round_done;
  logic w_fin_dec;
  logic w_fin_err;
  logic w_timeout;

  hs_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_nxt != r_state),
    .i_enable (is_wait_state(r_state)),
    .o_expired(w_expired)
  );

  always_comb begin
    w_nxt        = r_state;
    w_start      = 1'b0;
    w_capture    = 1'b0;
    w_load_reply = 1'b0;
    w_round_done = 1'b0;
    w_fin_dec    = 1'b0;
    w_fin_err    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_enable && !i_cts) begin
          w_start = 1'b1;
          w_nxt   = ST_REQ;
        end
      end
      ST_REQ: begin
        // A cts still high from the previous round must drop before it counts.
        if (i_cts && r_cts_low) begin
          w_capture = 1'b1;
          w_nxt     = ST_EVAL;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_nxt     = ST_IDLE;
        end
      end
      ST_EVAL: begin
        if (r_cap == DECISION) begin
          w_fin_dec = 1'b1;
          w_nxt     = ST_FIN;
        end else if (r_rounds == MAXR) begin
          w_fin_err = 1'b1;
          w_nxt     = ST_FIN;
        end else begin
          w_load_reply = 1'b1;
          w_nxt        = ST_WAITCTR;
        end
      end
      ST_WAITCTR: begin
        if (i_ctr) begin
          w_nxt = ST_SEND;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_nxt     = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!i_ctr) begin
          w_round_done = 1'b1;
          w_nxt        = ST_REL;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_nxt     = ST_IDLE;
        end
      end
      ST_REL:  w_nxt = ST_REQ;
      ST_FIN:  w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cap     <= '0;
      r_m       <= '0;
      r_v_in    <= '0;
      r_cts_low <= 1'b0;
      r_rtr     <= 1'b0;
      r_rts     <= 1'b0;
      r_done    <= 1'b0;
      r_decided <= 1'b0;
      r_error   <= 1'b0;
      r_rounds  <= '0;
    end else begin
      r_state <= w_nxt;

      if (w_capture) begin
        r_cap <= i_v_out;
        r_m   <= i_mask;
      end

      if (w_load_reply) begin
        r_v_in <= r_cap ^ r_m;
      end

      if (w_start) begin
        r_cts_low <= 1'b1;
      end else if (w_round_done) begin
        r_cts_low <= 1'b0;
      end else if ((r_state == ST_REQ) && !i_cts) begin
        r_cts_low <= 1'b1;
      end

      // Moore outputs registered from the next state so they line up with it.
      r_rtr  <= (w_nxt == ST_REQ) || (w_nxt == ST_EVAL) ||
                (w_nxt == ST_WAITCTR) || (w_nxt == ST_SEND);
      r_rts  <= (w_nxt == ST_SEND);
      r_done <= (w_nxt == ST_FIN) || w_timeout;

      if (w_start) begin
        r_decided <= 1'b0;
        r_error   <= 1'b0;
        r_rounds  <= '0;
      end else begin
        if (w_fin_dec) begin
          r_decided <= 1'b1;
        end
        if (w_fin_err || w_timeout) begin
          r_error <= 1'b1;
        end
        if (w_round_done && (r_rounds != MAXR)) begin
          r_rounds <= r_rounds + 1'b1;
        end
      end
    end
  end

  assign o_rtr     = r_rtr;
  assign o_rts     = r_rts;
  assign o_v_in    = r_v_in;
  assign o_done    = r_done;
  assign o_decided = r_decided;
  assign o_error   = r_error;
  assign o_rounds  = r_rounds;

endmodule
